// File: rtl/imm_operand_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer and a sideband tag.
// Optional build macro IMM_ZICSR_EN adds the CSR uimm (ZTYPE, code 3'd6) immediate.
module imm_operand_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      In,
  input  logic [2:0]       Type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ill
);

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;
  localparam logic [2:0] ZTYPE = 3'd6;

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_operand_pipe: XLEN must be 32 or 64");
  end

  // Returns {ill, imm}; every format is built as a 32-bit value, then sign-extended to XLEN.
  function automatic logic [XLEN:0] decode_imm(input logic [24:0] in_bits, input logic [2:0] typ);
    logic [31:0] ins;
    logic [31:0] v;
    logic        ill;
    ins = {in_bits, 7'd0};
    v   = 32'd0;
    ill = 1'b0;
    case (typ)
      RTYPE: v = 32'd0;
      ITYPE: v = 32'($signed(ins[31:20]));
      STYPE: v = 32'($signed({ins[31:25], ins[11:7]}));
      BTYPE: v = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      UTYPE: v = {ins[31:12], 12'd0};
      JTYPE: v = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
`ifdef IMM_ZICSR_EN
      ZTYPE: v = {27'd0, ins[19:15]};
`endif
      default: begin
        v   = 32'd0;
        ill = 1'b1;
      end
    endcase
    return {ill, XLEN'($signed(v))};
  endfunction

  logic             r_m_valid;
  logic [XLEN-1:0]  r_m_imm;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_m_ill;
  logic             r_s_valid;
  logic [XLEN-1:0]  r_s_imm;
  logic [TAG_W-1:0] r_s_tag;
  logic             r_s_ill;

  logic             w_accept;
  logic             w_m_free;
  logic [XLEN:0]    w_dec;

  assign w_accept = in_valid & ~r_s_valid;
  assign w_m_free = ~r_m_valid | out_ready;

  // Decode on the input side so entries are stored already extended.
  always_comb begin
    w_dec = '0;
    w_dec = decode_imm(In, Type);
  end

  // Main/skid register update; M refills from S first to keep FIFO order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_imm   <= '0;
      r_m_tag   <= '0;
      r_m_ill   <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_imm   <= '0;
      r_s_tag   <= '0;
      r_s_ill   <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_m_free) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_imm   <= r_s_imm;
        r_m_tag   <= r_s_tag;
        r_m_ill   <= r_s_ill;
        r_s_valid <= 1'b0;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_imm   <= w_dec[XLEN-1:0];
        r_m_tag   <= in_tag;
        r_m_ill   <= w_dec[XLEN];
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_s_valid <= 1'b1;
      r_s_imm   <= w_dec[XLEN-1:0];
      r_s_tag   <= in_tag;
      r_s_ill   <= w_dec[XLEN];
    end else begin
      r_s_valid <= r_s_valid;
    end
  end

  assign in_ready  = ~r_s_valid;
  assign out_valid = r_m_valid;
  assign out_imm   = r_m_imm;
  assign out_tag   = r_m_tag;
  assign out_ill   = r_m_ill;

endmodule

// File: tb/tb_imm_operand_pipe.sv
// Self-checking bench: 2-deep FIFO reference model plus directed literal expectations,
// run against an XLEN=32 and an XLEN=64 instance sharing the same stimulus.
module tb_imm_operand_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [24:0] In;
  logic [2:0]  Type;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        o32_in_ready, o32_valid, o32_ill;
  logic [31:0] o32_imm, o32_tag;
  logic        o64_in_ready, o64_valid, o64_ill;
  logic [63:0] o64_imm;
  logic [31:0] o64_tag;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } entry_t;
  entry_t q[$];

  imm_operand_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o32_in_ready),
    .In(In), .Type(Type), .in_tag(in_tag), .out_valid(o32_valid), .out_ready(out_ready),
    .out_imm(o32_imm), .out_tag(o32_tag), .out_ill(o32_ill));

  imm_operand_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o64_in_ready),
    .In(In), .Type(Type), .in_tag(in_tag), .out_valid(o64_valid), .out_ready(out_ready),
    .out_imm(o64_imm), .out_tag(o64_tag), .out_ill(o64_ill));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate computed with integer shifts and weights on the full instruction word.
  function automatic entry_t model_decode(input logic [24:0] in_bits, input logic [2:0] typ, input logic [31:0] tag);
    entry_t e;
    int     sv;
    longint r;
    sv    = int'({in_bits, 7'd0});
    r     = 0;
    e.ill = 1'b0;
    case (typ)
      3'd0: r = 0;
      3'd1: r = sv >>> 20;
      3'd2: r = ((sv >>> 25) * 32) + ((sv >> 7) & 31);
      3'd3: r = ((sv >>> 31) * 4096) + (((sv >> 7) & 1) * 2048) + (((sv >> 25) & 63) * 32) + (((sv >> 8) & 15) * 2);
      3'd4: r = (sv >>> 12) * 4096;
      3'd5: r = ((sv >>> 31) * 1048576) + (((sv >> 12) & 255) * 4096) + (((sv >> 20) & 1) * 2048) + (((sv >> 21) & 1023) * 2);
`ifdef IMM_ZICSR_EN
      3'd6: r = (sv >> 15) & 31;
`endif
      default: begin
        r     = 0;
        e.ill = 1'b1;
      end
    endcase
    e.imm = 64'(r);
    e.tag = tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Model update: a 2-entry FIFO with reset/flush emptying it.
  always @(posedge clk) begin
    bit acc, fir;
    acc = in_valid && (q.size() < 2);
    fir = out_ready && (q.size() > 0);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back(model_decode(In, Type, in_tag));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid32", 64'(o32_valid), 64'(q.size() > 0));
      check("ready32", 64'(o32_in_ready), 64'(q.size() < 2));
      check("valid64", 64'(o64_valid), 64'(q.size() > 0));
      check("ready64", 64'(o64_in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        check("imm32", 64'(o32_imm), 64'(q[0].imm[31:0]));
        check("tag32", 64'(o32_tag), 64'(q[0].tag));
        check("ill32", 64'(o32_ill), 64'(q[0].ill));
        check("imm64", o64_imm, q[0].imm);
        check("tag64", 64'(o64_tag), 64'(q[0].tag));
        check("ill64", 64'(o64_ill), 64'(q[0].ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] typ, input logic [31:0] tag);
    logic [31:0] w;
    w        = instr;
    in_valid = 1'b1;
    In       = w[31:7];
    Type     = typ;
    in_tag   = tag;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; In = 25'd0; Type = 3'd0;
    in_tag = 32'd0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(o32_valid), 64'd0);
    check("rst_ready", 64'(o32_in_ready), 64'd1);
    check("rst_imm64", o64_imm, 64'd0);
    check("rst_tag", 64'(o32_tag), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // ITYPE addi -1
    drive(32'hFFF00093, 3'd1, 32'd10); tick(); in_valid = 1'b0;
    check("i_valid", 64'(o32_valid), 64'd1);
    check("i_imm32", 64'(o32_imm), 64'h0000_0000_FFFF_FFFF);
    check("i_ill", 64'(o32_ill), 64'd0);
    tick();
    // BTYPE beq -4, JTYPE jal +8 back-to-back
    drive(32'hFE000EE3, 3'd3, 32'd11); tick();
    check("b_imm32", 64'(o32_imm), 64'h0000_0000_FFFF_FFFC);
    drive(32'h0080006F, 3'd5, 32'd12); tick(); in_valid = 1'b0;
    check("j_imm32", 64'(o32_imm), 64'h0000_0000_0000_0008);
    tick();
    // UTYPE on both widths
    drive(32'h12345037, 3'd4, 32'd13); tick();
    check("u_pos64", o64_imm, 64'h0000_0000_1234_5000);
    drive(32'h80000037, 3'd4, 32'd14); tick(); in_valid = 1'b0;
    check("u_neg64", o64_imm, 64'hFFFF_FFFF_8000_0000);
    check("u_neg32", 64'(o32_imm), 64'h0000_0000_8000_0000);
    tick();
    // STYPE and RTYPE through the model only
    drive(32'hFE112E23, 3'd2, 32'd15); tick();
    drive(32'h00B50533, 3'd0, 32'd16); tick(); in_valid = 1'b0;
    tick();

    // Stall: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    drive(32'h00100093, 3'd1, 32'd1); tick();
    drive(32'h00200093, 3'd1, 32'd2); tick();
    check("stall_ready", 64'(o32_in_ready), 64'd0);
    drive(32'h00300093, 3'd1, 32'd3); tick();
    check("stall_head", 64'(o32_tag), 64'd1);
    out_ready = 1'b1; tick();
    check("drain_t2", 64'(o32_tag), 64'd2);
    tick(); in_valid = 1'b0;
    check("drain_t3", 64'(o32_tag), 64'd3);
    check("drain_v3", 64'(o32_valid), 64'd1);
    tick();

    // Flush with both registers full and an input offered
    out_ready = 1'b0;
    drive(32'h00400093, 3'd1, 32'd21); tick();
    drive(32'h00500093, 3'd1, 32'd22); tick();
    drive(32'h00600093, 3'd1, 32'd23); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(o32_valid), 64'd0);
    check("flush_ready", 64'(o32_in_ready), 64'd1);
    out_ready = 1'b1;
    drive(32'h00700093, 3'd1, 32'd24); tick(); in_valid = 1'b0;
    check("post_flush_tag", 64'(o32_tag), 64'd24);
    check("post_flush_imm", 64'(o32_imm), 64'd7);
    tick();

    // Reset mid-stall
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd1, 32'd31); tick();
    drive(32'hFFF00093, 3'd1, 32'd32); tick();
    in_valid = 1'b0; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("rst2_valid", 64'(o64_valid), 64'd0);
    check("rst2_imm", o64_imm, 64'd0);
    check("rst2_tag", 64'(o64_tag), 64'd0);
    check("rst2_ill", 64'(o64_ill), 64'd0);
    check("rst2_ready", 64'(o64_in_ready), 64'd1);
    out_ready = 1'b1;

    // CSR uimm (code 6) and illegal code 7
    drive(32'h000A8000, 3'd6, 32'd41); tick();
`ifdef IMM_ZICSR_EN
    check("z_imm", 64'(o32_imm), 64'h15);
    check("z_ill", 64'(o32_ill), 64'd0);
`else
    check("z_imm", 64'(o32_imm), 64'd0);
    check("z_ill", 64'(o32_ill), 64'd1);
`endif
    drive(32'hFFFFFF80, 3'd7, 32'd42); tick(); in_valid = 1'b0;
    check("t7_ill", 64'(o32_ill), 64'd1);
    check("t7_imm", o64_imm, 64'd0);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
